// File: rtl/raizing_extratext_ram.sv
// Memory responder for the extra-text layer.
// Owns the text VRAM, the line-select RAM and the line-scroll RAM. Each memory is dual-port:
//   - renderer side: read-only, 2-cycle latency (address register, then data register), never stalled
//   - shared side:   zero-fill writes from the post-reset sweep, or CPU accesses via req/ack handshake
// Ports:
//   CLK96, RESET96                     clock, asynchronous active-high reset
//   TEXTVRAM_ADDR / TEXTVRAM_DATA      renderer VRAM read port
//   TEXTSELECT_ADDR / TEXTSELECT_DATA  renderer select-RAM read port
//   TEXTSCROLL_ADDR / TEXTSCROLL_DATA  renderer scroll-RAM read port
//   CPU_CS_VRAM/SEL/SCR, CPU_ADDR, CPU_RNW, CPU_UDS_N, CPU_LDS_N, CPU_DIN   CPU request
//   CPU_DOUT, CPU_ACK                  CPU response (held until all chip selects drop)
//   CLEAR_BUSY                         zero-fill sweep in progress
module raizing_extratext_ram #(
  parameter int unsigned VRAM_AW        = 12,
  parameter int unsigned LINE_AW        = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               CLK96,
  input  logic               RESET96,
  input  logic [VRAM_AW-1:0] TEXTVRAM_ADDR,
  output logic [15:0]        TEXTVRAM_DATA,
  input  logic [LINE_AW-1:0] TEXTSELECT_ADDR,
  output logic [15:0]        TEXTSELECT_DATA,
  input  logic [LINE_AW-1:0] TEXTSCROLL_ADDR,
  output logic [15:0]        TEXTSCROLL_DATA,
  input  logic               CPU_CS_VRAM,
  input  logic               CPU_CS_SEL,
  input  logic               CPU_CS_SCR,
  input  logic [VRAM_AW-1:0] CPU_ADDR,
  input  logic               CPU_RNW,
  input  logic               CPU_UDS_N,
  input  logic               CPU_LDS_N,
  input  logic [15:0]        CPU_DIN,
  output logic [15:0]        CPU_DOUT,
  output logic               CPU_ACK,
  output logic               CLEAR_BUSY
);

  localparam int unsigned VRAM_WORDS = 1 << VRAM_AW;
  localparam int unsigned LINE_WORDS = 1 << LINE_AW;
  localparam logic [VRAM_AW-1:0] VRAM_ONE = {{(VRAM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StWrite, StRdAddr, StRdData, StHold} state_e;
  typedef enum logic [1:0] {TgtVram, TgtSel, TgtScr} tgt_e;

  logic [15:0] r_vram [0:VRAM_WORDS-1];
  logic [15:0] r_sel  [0:LINE_WORDS-1];
  logic [15:0] r_scr  [0:LINE_WORDS-1];

  // Zero-fill sweep
  logic               r_clear_busy;
  logic [VRAM_AW-1:0] r_clear_cnt;

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_clear_busy <= (CLEAR_ON_RESET != 0);
      r_clear_cnt  <= '0;
    end else if (r_clear_busy) begin
      r_clear_cnt <= r_clear_cnt + VRAM_ONE;
      if (&r_clear_cnt) r_clear_busy <= 1'b0;
    end
  end

  // CPU FSM registers
  state_e             r_state;
  tgt_e               r_tgt;
  logic [VRAM_AW-1:0] r_cpu_raddr;
  logic [15:0]        r_dout;
  logic               r_ack;

  logic       w_any_cs;
  logic [1:0] w_cpu_be;
  assign w_any_cs = CPU_CS_VRAM | CPU_CS_SEL | CPU_CS_SCR;
  assign w_cpu_be = {~CPU_UDS_N, ~CPU_LDS_N};

  // Shared write port: the sweep owns it while busy, otherwise the CPU in StWrite.
  // The requester holds address/data stable until ACK, so they are used unregistered.
  logic [VRAM_AW-1:0] w_waddr;
  logic [15:0]        w_wdata;
  logic [1:0]         w_be_vram, w_be_sel, w_be_scr;

  always_comb begin
    w_waddr   = CPU_ADDR;
    w_wdata   = CPU_DIN;
    w_be_vram = 2'b00;
    w_be_sel  = 2'b00;
    w_be_scr  = 2'b00;
    if (r_clear_busy) begin
      w_waddr   = r_clear_cnt;
      w_wdata   = 16'h0000;
      w_be_vram = 2'b11;
      if (r_clear_cnt[VRAM_AW-1:LINE_AW] == '0) begin
        w_be_sel = 2'b11;
        w_be_scr = 2'b11;
      end
    end else if (r_state == StWrite) begin
      case (r_tgt)
        TgtVram: w_be_vram = w_cpu_be;
        TgtSel:  w_be_sel  = w_cpu_be;
        TgtScr:  w_be_scr  = w_cpu_be;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK96) begin
    if (w_be_vram[1]) r_vram[w_waddr][15:8] <= w_wdata[15:8];
    if (w_be_vram[0]) r_vram[w_waddr][7:0]  <= w_wdata[7:0];
    if (w_be_sel[1])  r_sel[w_waddr[LINE_AW-1:0]][15:8] <= w_wdata[15:8];
    if (w_be_sel[0])  r_sel[w_waddr[LINE_AW-1:0]][7:0]  <= w_wdata[7:0];
    if (w_be_scr[1])  r_scr[w_waddr[LINE_AW-1:0]][15:8] <= w_wdata[15:8];
    if (w_be_scr[0])  r_scr[w_waddr[LINE_AW-1:0]][7:0]  <= w_wdata[7:0];
  end

  // Renderer read ports. Reading the array on the same edge as a write returns the old word.
  logic [VRAM_AW-1:0] r_vram_raddr;
  logic [LINE_AW-1:0] r_sel_raddr, r_scr_raddr;
  logic [15:0]        r_vram_q, r_sel_q, r_scr_q;

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_vram_raddr <= '0;
      r_sel_raddr  <= '0;
      r_scr_raddr  <= '0;
      r_vram_q     <= '0;
      r_sel_q      <= '0;
      r_scr_q      <= '0;
    end else begin
      r_vram_raddr <= TEXTVRAM_ADDR;
      r_sel_raddr  <= TEXTSELECT_ADDR;
      r_scr_raddr  <= TEXTSCROLL_ADDR;
      r_vram_q     <= r_vram[r_vram_raddr];
      r_sel_q      <= r_sel[r_sel_raddr];
      r_scr_q      <= r_scr[r_scr_raddr];
    end
  end

  // Memory contents are undefined until the sweep completes, so mask them.
  assign TEXTVRAM_DATA   = r_clear_busy ? 16'h0000 : r_vram_q;
  assign TEXTSELECT_DATA = r_clear_busy ? 16'h0000 : r_sel_q;
  assign TEXTSCROLL_DATA = r_clear_busy ? 16'h0000 : r_scr_q;

  // CPU handshake FSM
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_state     <= StIdle;
      r_tgt       <= TgtVram;
      r_cpu_raddr <= '0;
      r_dout      <= '0;
      r_ack       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_cs && !r_clear_busy) begin
            if (CPU_CS_VRAM)     r_tgt <= TgtVram;
            else if (CPU_CS_SEL) r_tgt <= TgtSel;
            else                 r_tgt <= TgtScr;
            r_state <= CPU_RNW ? StRdAddr : StWrite;
          end
        end
        StWrite: begin
          r_ack   <= 1'b1;
          r_state <= StHold;
        end
        StRdAddr: begin
          r_cpu_raddr <= CPU_ADDR;
          r_state     <= StRdData;
        end
        StRdData: begin
          case (r_tgt)
            TgtVram: r_dout <= r_vram[r_cpu_raddr];
            TgtSel:  r_dout <= r_sel[r_cpu_raddr[LINE_AW-1:0]];
            TgtScr:  r_dout <= r_scr[r_cpu_raddr[LINE_AW-1:0]];
            default: r_dout <= r_dout;
          endcase
          r_ack   <= 1'b1;
          r_state <= StHold;
        end
        StHold: begin
          // Wait for a full deassertion so a held or re-asserted CS is not served twice.
          if (!w_any_cs) begin
            r_ack   <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign CPU_DOUT   = r_dout;
  assign CPU_ACK    = r_ack;
  assign CLEAR_BUSY = r_clear_busy;

endmodule

// File: tb/tb_raizing_extratext_ram.sv
// Directed bench for raizing_extratext_ram: reset sweep, CPU writes/reads, byte lanes,
// read-first collision, handshake hold and mid-operation reset.
module tb_raizing_extratext_ram;

  logic        CLK96;
  logic        RESET96;
  logic [11:0] TEXTVRAM_ADDR;
  logic [15:0] TEXTVRAM_DATA;
  logic [7:0]  TEXTSELECT_ADDR;
  logic [15:0] TEXTSELECT_DATA;
  logic [7:0]  TEXTSCROLL_ADDR;
  logic [15:0] TEXTSCROLL_DATA;
  logic        CPU_CS_VRAM, CPU_CS_SEL, CPU_CS_SCR;
  logic [11:0] CPU_ADDR;
  logic        CPU_RNW, CPU_UDS_N, CPU_LDS_N;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic        CPU_ACK;
  logic        CLEAR_BUSY;

  int errors = 0;
  int checks = 0;

  raizing_extratext_ram dut (
    .CLK96           (CLK96),
    .RESET96         (RESET96),
    .TEXTVRAM_ADDR   (TEXTVRAM_ADDR),
    .TEXTVRAM_DATA   (TEXTVRAM_DATA),
    .TEXTSELECT_ADDR (TEXTSELECT_ADDR),
    .TEXTSELECT_DATA (TEXTSELECT_DATA),
    .TEXTSCROLL_ADDR (TEXTSCROLL_ADDR),
    .TEXTSCROLL_DATA (TEXTSCROLL_DATA),
    .CPU_CS_VRAM     (CPU_CS_VRAM),
    .CPU_CS_SEL      (CPU_CS_SEL),
    .CPU_CS_SCR      (CPU_CS_SCR),
    .CPU_ADDR        (CPU_ADDR),
    .CPU_RNW         (CPU_RNW),
    .CPU_UDS_N       (CPU_UDS_N),
    .CPU_LDS_N       (CPU_LDS_N),
    .CPU_DIN         (CPU_DIN),
    .CPU_DOUT        (CPU_DOUT),
    .CPU_ACK         (CPU_ACK),
    .CLEAR_BUSY      (CLEAR_BUSY)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK96);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges until CLEAR_BUSY reads 0; optionally raise CPU_CS_VRAM at edge cs_at.
  task automatic run_sweep(input int cs_at, output int n, output logic ack_seen,
                           output logic data_seen);
    n = 0;
    ack_seen = 1'b0;
    data_seen = 1'b0;
    do begin
      TEXTVRAM_ADDR = n[0] ? 12'h040 : 12'h123;
      step();
      n++;
      if (n == cs_at) CPU_CS_VRAM = 1'b1;
      if (CPU_ACK !== 1'b0) ack_seen = 1'b1;
      if (CLEAR_BUSY && TEXTVRAM_DATA !== 16'h0000) data_seen = 1'b1;
    end while (CLEAR_BUSY && n < 5000);
    TEXTVRAM_ADDR = 12'h000;
  endtask

  // One complete handshake; lat = edges from driving the request to seeing ACK (99 = timeout).
  task automatic cpu_access(input logic [2:0] cs, input logic rnw, input logic [11:0] addr,
                            input logic [15:0] din, input logic uds_n, input logic lds_n,
                            output int lat, output logic [15:0] dout, output logic ack_after);
    {CPU_CS_VRAM, CPU_CS_SEL, CPU_CS_SCR} = cs;
    CPU_RNW   = rnw;
    CPU_ADDR  = addr;
    CPU_DIN   = din;
    CPU_UDS_N = uds_n;
    CPU_LDS_N = lds_n;
    lat = 0;
    do begin
      step();
      lat++;
    end while (CPU_ACK !== 1'b1 && lat < 20);
    if (CPU_ACK !== 1'b1) lat = 99;
    dout = CPU_DOUT;
    {CPU_CS_VRAM, CPU_CS_SEL, CPU_CS_SCR} = 3'b000;
    step();
    ack_after = CPU_ACK;
  endtask

  task automatic render_read(input logic [11:0] va, input logic [7:0] sa, input logic [7:0] ca,
                             output logic [15:0] vd, output logic [15:0] sd,
                             output logic [15:0] cd);
    TEXTVRAM_ADDR   = va;
    TEXTSELECT_ADDR = sa;
    TEXTSCROLL_ADDR = ca;
    step(2);
    vd = TEXTVRAM_DATA;
    sd = TEXTSELECT_DATA;
    cd = TEXTSCROLL_DATA;
  endtask

  int          n, lat;
  logic        ack_seen, data_seen, hold_ok, ack_after;
  logic [15:0] dout, vd, sd, cd;

  initial begin
    RESET96 = 1'b1;
    TEXTVRAM_ADDR = '0; TEXTSELECT_ADDR = '0; TEXTSCROLL_ADDR = '0;
    {CPU_CS_VRAM, CPU_CS_SEL, CPU_CS_SCR} = 3'b000;
    CPU_ADDR = 12'h123; CPU_RNW = 1'b0; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    CPU_DIN = 16'hBEEF;
    #2;
    chk("rst_ack", {31'd0, CPU_ACK}, 32'd0);
    chk("rst_dout", {16'd0, CPU_DOUT}, 32'd0);
    chk("rst_busy", {31'd0, CLEAR_BUSY}, 32'd1);
    chk("rst_vdata", {16'd0, TEXTVRAM_DATA}, 32'd0);
    step(3);
    RESET96 = 1'b0;

    // Sweep with a VRAM write request (0x123 = 0xBEEF) pending from cycle 10.
    run_sweep(10, n, ack_seen, data_seen);
    chk("sweep_len", n, 32'd4096);
    chk("sweep_no_ack", {31'd0, ack_seen}, 32'd0);
    chk("sweep_vdata_zero", {31'd0, data_seen}, 32'd0);
    step();  // IDLE samples the request here
    chk("wr_no_ack_at_sample", {31'd0, CPU_ACK}, 32'd0);
    step();
    chk("wr_ack_next", {31'd0, CPU_ACK}, 32'd1);

    // Hold CS for 20 cycles after ACK; changed DIN must never be written.
    CPU_DIN = 16'h5555;
    TEXTVRAM_ADDR = 12'h123;
    step();
    chk("vram_lat_1cyc_old", {16'd0, TEXTVRAM_DATA}, 32'h0000);
    step();
    chk("vram_lat_2cyc", {16'd0, TEXTVRAM_DATA}, 32'hBEEF);
    hold_ok = (CPU_ACK === 1'b1);
    for (int i = 0; i < 18; i++) begin
      step();
      if (CPU_ACK !== 1'b1) hold_ok = 1'b0;
    end
    chk("hold_ack", {31'd0, hold_ok}, 32'd1);
    chk("hold_single_write", {16'd0, TEXTVRAM_DATA}, 32'hBEEF);
    CPU_CS_VRAM = 1'b0;
    step();
    chk("ack_drop", {31'd0, CPU_ACK}, 32'd0);

    // Both VRAM and SEL selected: only VRAM is written.
    cpu_access(3'b110, 1'b0, 12'h040, 16'h1234, 1'b0, 1'b0, lat, dout, ack_after);
    chk("dual_cs_wr_lat", lat, 32'd2);
    chk("dual_cs_ack_release", {31'd0, ack_after}, 32'd0);
    render_read(12'h040, 8'h40, 8'h06, vd, sd, cd);
    chk("dual_cs_vram", {16'd0, vd}, 32'h1234);
    chk("dual_cs_sel_untouched", {16'd0, sd}, 32'h0000);

    // Byte lanes on SEL[0x40].
    cpu_access(3'b010, 1'b0, 12'h040, 16'h1234, 1'b0, 1'b0, lat, dout, ack_after);
    cpu_access(3'b010, 1'b0, 12'h040, 16'hABCD, 1'b0, 1'b1, lat, dout, ack_after);
    cpu_access(3'b010, 1'b1, 12'h040, 16'h0000, 1'b1, 1'b1, lat, dout, ack_after);
    chk("sel_rd_lat", lat, 32'd3);
    chk("sel_rd_data", {16'd0, dout}, 32'hAB34);
    render_read(12'h040, 8'h40, 8'h06, vd, sd, cd);
    chk("sel_render", {16'd0, sd}, 32'hAB34);

    // Read-first collision on SCR[5].
    cpu_access(3'b001, 1'b0, 12'h005, 16'h0011, 1'b0, 1'b0, lat, dout, ack_after);
    CPU_CS_SCR = 1'b1;
    CPU_ADDR = 12'h005;
    CPU_DIN = 16'h0022;
    TEXTSCROLL_ADDR = 8'h05;
    step();  // address registered, FSM -> WRITE
    step();  // array write and renderer array read on the same edge
    chk("collide_ack", {31'd0, CPU_ACK}, 32'd1);
    chk("collide_old", {16'd0, TEXTSCROLL_DATA}, 32'h0011);
    step();
    chk("collide_new", {16'd0, TEXTSCROLL_DATA}, 32'h0022);
    CPU_CS_SCR = 1'b0;
    step();

    // Reset while the FSM sits in RD_ADDR.
    CPU_CS_VRAM = 1'b1;
    CPU_RNW = 1'b1;
    CPU_ADDR = 12'h123;
    step();
    chk("pre_reset_dout", {16'd0, CPU_DOUT}, 32'hAB34);
    RESET96 = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, CPU_ACK}, 32'd0);
    chk("midrst_dout", {16'd0, CPU_DOUT}, 32'd0);
    chk("midrst_busy", {31'd0, CLEAR_BUSY}, 32'd1);
    CPU_CS_VRAM = 1'b0;
    step(2);
    RESET96 = 1'b0;
    run_sweep(-1, n, ack_seen, data_seen);
    chk("resweep_len", n, 32'd4096);
    chk("resweep_vdata_zero", {31'd0, data_seen}, 32'd0);
    render_read(12'h123, 8'h40, 8'h05, vd, sd, cd);
    chk("resweep_vram_cleared", {16'd0, vd}, 32'h0000);
    chk("resweep_sel_cleared", {16'd0, sd}, 32'h0000);
    chk("resweep_scr_cleared", {16'd0, cd}, 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raizing_extratext_ram.md
Name: raizing_extratext_ram

Overview:
- CPU-facing memory responder for the extra-text layer.
- Owns the text VRAM (4096x16), line-select RAM (256x16) and line-scroll RAM (256x16).
- Answers the text renderer's read ports with fixed 2-cycle latency.
- Serves 68k-style CPU reads and writes through a request/acknowledge handshake, and zero-fills all three memories after reset.

Parameters:
- VRAM_AW, 12, text VRAM word-address width (4096 words).
- LINE_AW, 8, select/scroll RAM word-address width (256 words each).
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after reset; 0 = skip the sweep, CLEAR_BUSY stays 0.

Ports:
- CLK96  in  1  system clock; all logic on its rising edge.
- RESET96  in  1  asynchronous, active-high reset.
- TEXTVRAM_ADDR  in  12  renderer VRAM word address.
- TEXTVRAM_DATA  out  16  renderer VRAM read data.
- TEXTSELECT_ADDR  in  8  renderer select-RAM address.
- TEXTSELECT_DATA  out  16  select read data.
- TEXTSCROLL_ADDR  in  8  renderer scroll-RAM address.
- TEXTSCROLL_DATA  out  16  scroll read data.
- CPU_CS_VRAM  in  1  CPU selects text VRAM.
- CPU_CS_SEL  in  1  CPU selects select RAM.
- CPU_CS_SCR  in  1  CPU selects scroll RAM.
- CPU_ADDR  in  12  CPU word address; [7:0] used for select/scroll.
- CPU_RNW  in  1  1 = read, 0 = write.
- CPU_UDS_N  in  1  upper-byte strobe, active low.
- CPU_LDS_N  in  1  lower-byte strobe, active low.
- CPU_DIN  in  16  CPU write data.
- CPU_DOUT  out  16  CPU read data.
- CPU_ACK  out  1  access complete.
- CLEAR_BUSY  out  1  zero-fill in progress.

Behaviour:
- Reset values: all data outputs 0, CPU_ACK=0, CLEAR_BUSY=CLEAR_ON_RESET, CPU FSM in IDLE, clear counter 0.
- Renderer ports:
  - Address registered at edge N, memory output registered at N+1; data valid 2 cycles after the address is presented.
  - Continuous and never stalled; renderer reads always have priority.
  - Memories are true dual-port; the renderer uses a read-only port.
- Read/write collision: CPU write and renderer read to the same word on the same edge -> renderer gets the old data (read-first). The following read returns the new data.
- Clear sweep:
  - After RESET96 deasserts, a 12-bit counter runs 0..4095, one word per cycle.
  - Writes 0 to VRAM[cnt]; while cnt<256 also writes 0 to SEL[cnt] and SCR[cnt].
  - CLEAR_BUSY drops on the cycle after cnt=4095 is written (4096 cycles).
  - Renderer data outputs are forced to 0 while CLEAR_BUSY=1.
  - CPU requests are held off (no ACK) until the sweep ends.
- CPU FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, HOLD.
  - IDLE: a request is any CS high with CLEAR_BUSY=0. Priority VRAM > SEL > SCR; exactly one memory is accessed. CPU_RNW=0 -> WRITE, else -> RD_ADDR.
  - WRITE: one cycle. Writes CPU_DIN[15:8] if UDS_N=0 and CPU_DIN[7:0] if LDS_N=0. Both strobes high -> no write, still acknowledged. Sets CPU_ACK=1 -> HOLD.
  - RD_ADDR: CPU address applied to the CPU port -> RD_DATA.
  - RD_DATA: full 16-bit word latched into CPU_DOUT, CPU_ACK=1 -> HOLD. Strobes are ignored on reads.
  - HOLD: CPU_ACK stays 1 and CPU_DOUT stays stable until all CS are low, then CPU_ACK=0 -> IDLE. CS re-asserted without a gap remains in HOLD; no double access.
- Latency:
  - Write: request sampled at edge N, memory written and ACK high at N+1.
  - Read: ACK and data at N+2 after IDLE samples the request.
- CPU inputs are synchronous to CLK96; the requester holds ADDR, DIN, RNW and strobes stable until ACK.
- Reset mid-operation: ACK drops immediately, the FSM returns to IDLE, and the sweep restarts from 0.
- Address widths: select/scroll ignore CPU_ADDR[11:8]; no wrap logic is needed beyond natural truncation.

Test Plan:
- Reset, then hold CPU_CS_VRAM=1 write from cycle 10 -> CLEAR_BUSY=1 for exactly 4096 cycles, CPU_ACK stays 0 until the sweep ends; TEXTVRAM_DATA=0 for any address during the sweep.
- CPU write VRAM[0x123]=0xBEEF (both strobes) -> ACK one cycle after sampling. Renderer presents 0x123 -> TEXTVRAM_DATA=0xBEEF two cycles later.
- Byte lanes: SEL[0x40]=0x1234, then write 0xAB CD with UDS_N=0 and LDS_N=1 -> CPU read of SEL[0x40] returns 0xAB34 with ACK 2 cycles after request.
- Collision: SCR[5]=0x0011, then the CPU writes 0x0022 on the same edge the renderer presents address 5 -> renderer sees 0x0011; the next renderer read sees 0x0022.
- Handshake: hold CS high 20 cycles after ACK -> ACK stays 1, only one write occurs. Drop CS -> ACK=0 the next cycle. Reassert with CPU_CS_VRAM and CPU_CS_SEL both high -> only VRAM accessed.
- Assert RESET96 during RD_ADDR -> CPU_ACK=0 and CPU_DOUT=0 immediately, CLEAR_BUSY=1, sweep restarts at counter 0.
